sort_stream_adapter: RTL and testbench
======================================

// Module: sort_stream_adapter
// PURPOSE
//  Stream-side front/back end for the parallel sorter hardware_sort_ON.
//  - Collects N words from a valid/ready input stream and presents them as a parallel array.
//  - Pulses the sorter's load/reset input and waits the fixed sort time.
//  - Captures the sorted array and replays it as a valid/ready output stream with a last flag.
//  Sits between byte-stream producers/consumers and the sorter instance.
// PARAMETERS
//  N            5   words per frame (sorter width)
//  W            8   bits per word
//  SORT_CYCLES  5   clocks the sorter needs after load before numbers_out is valid (>=1)
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  in_valid     in   1      input word valid
//  in_ready     out  1      adapter can accept an input word
//  in_data      in   W      input word
//  sort_load    out  1      drives sorter reset/load port; one-cycle pulse
//  sort_data    out  N x W  drives sorter numbers_in; index 0 = first word received
//  sort_result  in   N x W  from sorter numbers_out; index 0 = smallest
//  out_valid    out  1      output word valid
//  out_ready    in   1      downstream accepts output word
//  out_data     out  W      output word, ascending order
//  out_last     out  1      marks word N-1 of the frame
//  busy         out  1      high in LOAD/SORT/EMIT
// BEHAVIOUR
//  Reset: state=COLLECT; idx, cnt, oidx=0; in-buffer and out-buffer=0.
//   While reset is high: in_ready=0, sort_load=0, out_valid=0, out_last=0, out_data=0, busy=0.
//  Reset mid-operation (any state): the frame is discarded with no partial output; restart in COLLECT.
//  FSM states: COLLECT -> LOAD -> SORT -> EMIT -> COLLECT.
//  COLLECT:
//   - in_ready=1.
//   - On in_valid&&in_ready: buf[idx]<=in_data and idx++.
//   - Accepting word idx==N-1: idx<=0 and go to LOAD.
//   - in_valid gaps are allowed; nothing times out.
//  LOAD:
//   - sort_load=1 for exactly this one cycle; cnt<=0; go to SORT.
//  SORT:
//   - cnt++ each cycle.
//   - At cnt==SORT_CYCLES-1: obuf<=sort_result and go to EMIT.
//  sort_data is driven from buf continuously and is stable from LOAD through SORT.
//  in_ready=0 in LOAD, SORT and EMIT; input words presented then are not taken.
//  EMIT:
//   - out_valid=1, out_data=obuf[oidx], out_last=(oidx==N-1).
//   - On out_ready: oidx++.
//   - On the last handshake: oidx<=0 and go to COLLECT.
//   - While out_ready=0: out_valid, out_data and out_last are held stable.
//  Latency: last input accepted at edge k -> sort_load high in cycle k+1 -> out_valid first high in cycle k+2+SORT_CYCLES.
//  Throughput: one word per cycle in and out. A new frame is accepted the cycle after the out_last handshake.
//  Widths:
//   - idx, oidx: $clog2(N) bits, never exceed N-1.
//   - cnt: $clog2(SORT_CYCLES)+1 bits.
//  Data is passed through unmodified. Duplicate values are legal and are emitted as the sorter returns them.
// STRUCTURE
//  Package sort_pkg holds:
//   - N and W defaults.
//   - typedef logic [W-1:0] word_t.
//   - typedef word_t frame_t [N].
//   - typedef enum {COLLECT, LOAD, SORT, EMIT} sort_adapt_state_t.
//  One sub-module: sort_stream_serializer.
//   - Holds obuf, oidx and out_* handshake for the EMIT side.
//   - Inputs: capture strobe and frame_t. Outputs: done pulse.
//  The FSM and input collection stay in the top module.
// TESTING
//  1. Basic frame: in 5,2,4,3,1 with in_valid held high and out_ready=1.
//     -> sort_data={5,2,4,3,1}; one sort_load pulse.
//     -> out 1,2,3,4,5 with out_last only on 5; first out_valid 7 cycles after the last accept.
//  2. Backpressure: frame 9,7,8,6,5 with out_ready toggling 0/1 each cycle.
//     -> out 5,6,7,8,9; out_data is stable while stalled; no word is dropped or duplicated.
//  3. Duplicates plus input gaps: 3,3,0,255,3 with in_valid low on alternate cycles.
//     -> out 0,3,3,3,255; busy stays 0 until the 5th accept.
//  4. Blocking: drive in_valid=1 during SORT and EMIT.
//     -> in_ready=0 and no buffer change; the next frame starts only after the out_last handshake.
//  5. Reset mid-SORT: assert reset 2 cycles after sort_load.
//     -> all outputs 0 immediately; after release a fresh frame 4,1,3,2,0 emits 0,1,2,3,4.
//  6. Back-to-back frames {5,2,4,3,1} then {10,20,30,40,50}.
//     -> 1..5 then 10..50; the second frame's first accept is in the cycle after the first out_last handshake.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types for the sorter stream adapter: frame geometry, word/frame types, FSM states.
package sort_pkg;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef logic [W-1:0] word_t;
  typedef word_t frame_t [N];

  typedef enum logic [1:0] {COLLECT, LOAD, SORT, EMIT} sort_adapt_state_t;
endpackage

// File: rtl/sort_stream_serializer.sv
// Replays a captured sorted frame as a valid/ready stream, one word per handshake.
// Output is held stable while out_ready is low; done pulses with the out_last handshake.
module sort_stream_serializer
  import sort_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   capture,
  input  frame_t result,
  input  logic   out_ready,
  output logic   out_valid,
  output word_t  out_data,
  output logic   out_last,
  output logic   done
);
  frame_t        obuf;
  logic [IW-1:0] oidx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obuf      <= '{default: '0};
      oidx      <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      obuf      <= result;
      oidx      <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (oidx == IW'(N - 1)) begin
        oidx      <= '0;
        out_valid <= 1'b0;
      end else begin
        oidx <= oidx + IW'(1);
      end
    end
  end

  // obuf is cleared on reset, so out_data reads 0 until the first capture
  assign out_data = obuf[oidx];
  assign out_last = out_valid && (oidx == IW'(N - 1));
  assign done     = out_last && out_ready;
endmodule

// File: rtl/sort_stream_adapter.sv
// Collects N stream words, pulses sort_load, waits SORT_CYCLES, then replays the sorted frame.
// First out_valid comes SORT_CYCLES+2 cycles after the last accept; in_ready is low from LOAD to the out_last handshake.
module sort_stream_adapter
  import sort_pkg::*;
#(
  parameter int SORT_CYCLES = 5
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  output logic   in_ready,
  input  word_t  in_data,
  output logic   sort_load,
  output frame_t sort_data,
  input  frame_t sort_result,
  output logic   out_valid,
  input  logic   out_ready,
  output word_t  out_data,
  output logic   out_last,
  output logic   busy
);
  localparam int CW = $clog2(SORT_CYCLES) + 1;

  sort_adapt_state_t state;
  frame_t            in_buf;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic              capture;
  logic              done;

  assign capture   = (state == SORT) && (cnt == CW'(SORT_CYCLES - 1));
  assign sort_data = in_buf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= COLLECT;
      in_buf    <= '{default: '0};
      idx       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      sort_load <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sort_load <= 1'b0;
      case (state)
        COLLECT: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_buf[idx] <= in_data;
            if (idx == IW'(N - 1)) begin
              // in_ready drops together with the last accept so no extra word slips in
              idx       <= '0;
              in_ready  <= 1'b0;
              sort_load <= 1'b1;
              busy      <= 1'b1;
              state     <= LOAD;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= SORT;
        end
        SORT: begin
          cnt <= cnt + CW'(1);
          if (capture) state <= EMIT;
        end
        EMIT: begin
          if (done) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  sort_stream_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .result    (sort_result),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );
endmodule

// File: tb/tb_sort_stream_adapter.sv
// Scoreboard bench for sort_stream_adapter with a behavioural sorter model and randomized frames.
module tb_sort_stream_adapter;
  import sort_pkg::*;

  localparam int SC = 5;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   in_valid = 1'b0;
  logic   in_ready;
  word_t  in_data = '0;
  logic   sort_load;
  frame_t sort_data;
  frame_t sort_result = '{default: '0};
  logic   out_valid;
  logic   out_ready = 1'b1;
  word_t  out_data;
  logic   out_last;
  logic   busy;

  sort_stream_adapter #(.SORT_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .sort_load   (sort_load),
    .sort_data   (sort_data),
    .sort_result (sort_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string msg);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  function automatic frame_t sorted(input frame_t f);
    frame_t r;
    word_t  t;
    r = f;
    for (int i = 1; i < N; i++)
      for (int j = i; j > 0; j--)
        if (r[j-1] > r[j]) begin
          t = r[j]; r[j] = r[j-1]; r[j-1] = t;
        end
    return r;
  endfunction

  // Scoreboard queues filled by the driver, drained by monitor and sorter model
  word_t exp_q[$];
  logic  exp_lq[$];
  word_t sent_w[$];
  int    exp_load_q[$];
  int    exp_first_q[$];
  int    last_done_edge = -1;
  int    epoch = 0;
  int    or_mode = 0;

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor
  logic  stall_prev = 1'b0;
  logic  v_prev = 1'b0;
  word_t d_prev = '0;
  logic  l_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
      v_prev     = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, d_prev);
        chk("hold_last", out_last, l_prev);
      end
      if (out_valid && !v_prev) begin
        if (exp_first_q.size() == 0) fail_event("unexpected out_valid rise, required none");
        else chk("first_valid_cycle", cyc, exp_first_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_word: got %0d, required no word", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
          chk("out_last", out_last, exp_lq.pop_front());
        end
        if (out_last) last_done_edge = cyc + 1;
      end
      stall_prev = out_valid && !out_ready;
      d_prev     = out_data;
      l_prev     = out_last;
      v_prev     = out_valid;
    end
  end

  // Sorter model: garbage until SORT_CYCLES clocks after load, then the sorted frame
  always @(negedge clk) begin
    if (!reset && sort_load) begin
      automatic frame_t cap = sort_data;
      automatic int     ep  = epoch;
      if (exp_load_q.size() == 0) fail_event("unexpected sort_load, required none");
      else chk("load_cycle", cyc, exp_load_q.pop_front());
      for (int i = 0; i < N; i++)
        if (sent_w.size() > 0) chk("sort_data", sort_data[i], sent_w.pop_front());
      for (int i = 0; i < N; i++) sort_result[i] = word_t'($urandom);
      for (int k = 0; k < SC; k++) begin
        @(negedge clk);
        if (ep == epoch && !reset) begin
          if (k == 0) chk("load_pulse_width", sort_load, 0);
          for (int i = 0; i < N; i++) chk("sort_data_stable", sort_data[i], cap[i]);
        end
      end
      sort_result = sorted(cap);
    end
  end

  task automatic send_frame(input frame_t w, input int gap_mode, input bit chk_b2b, input bit chk_busy);
    automatic frame_t s = sorted(w);
    automatic int i = 0;
    automatic int guard = 0;
    automatic bit phase = 1'b0;
    for (int j = 0; j < N; j++) begin
      exp_q.push_back(s[j]);
      exp_lq.push_back(j == N - 1);
      sent_w.push_back(w[j]);
    end
    while (i < N && guard < 1000) begin
      @(negedge clk);
      guard++;
      if ((gap_mode == 1 && phase) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = w[i];
      end
      phase = ~phase;
      if (chk_busy) chk("busy_while_collect", busy, 0);
      if (in_valid && in_ready) begin
        if (i == 0 && chk_b2b) chk("b2b_first_accept", cyc + 1, last_done_edge + 1);
        if (i == N - 1) begin
          exp_load_q.push_back(cyc + 1);
          exp_first_q.push_back(cyc + 2 + SC);
        end
        i++;
      end
    end
    if (i < N) fail_event("input accept timeout");
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    automatic int guard = 0;
    while (!(exp_q.size() == 0 && !out_valid) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) fail_event("drain timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_sort_load"}, sort_load, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fr;
    int     guard;
    bit     hit;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // 1: basic frame
    or_mode = 0;
    fr = '{8'd5, 8'd2, 8'd4, 8'd3, 8'd1};
    send_frame(fr, 0, 0, 0);
    idle();
    drain();

    // 2: backpressure
    or_mode = 1;
    fr = '{8'd9, 8'd7, 8'd8, 8'd6, 8'd5};
    send_frame(fr, 0, 0, 0);
    idle();
    drain();

    // 3: duplicates with input gaps
    or_mode = 0;
    fr = '{8'd3, 8'd3, 8'd0, 8'd255, 8'd3};
    send_frame(fr, 1, 0, 1);
    idle();
    chk("busy_after_last_accept", busy, 1);
    drain();

    // 4: input blocked while busy
    or_mode = 2;
    fr = '{8'd40, 8'd12, 8'd99, 8'd12, 8'd7};
    send_frame(fr, 0, 0, 0);
    guard = 0;
    hit   = 1'b0;
    while (!hit && guard < 300) begin
      @(negedge clk);
      guard++;
      in_valid = 1'b1;
      in_data  = word_t'($urandom);
      chk("in_ready_blocked", in_ready, 0);
      if (out_valid && out_ready && out_last) hit = 1'b1;
    end
    in_valid = 1'b0;
    if (!hit) fail_event("blocking test never saw out_last");
    @(negedge clk);
    chk("in_ready_returns", in_ready, 1);

    // 5: reset two cycles after sort_load
    or_mode = 0;
    fr = '{8'd50, 8'd60, 8'd10, 8'd20, 8'd30};
    send_frame(fr, 0, 0, 0);
    idle();
    guard = 0;
    while (!sort_load && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!sort_load) fail_event("sort_load never seen before reset test");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    epoch++;
    #1;
    check_reset_outputs("midrst");
    for (int j = 0; j < N; j++) begin
      void'(exp_q.pop_back());
      void'(exp_lq.pop_back());
    end
    void'(exp_first_q.pop_back());
    repeat (3) @(negedge clk);
    reset = 1'b0;
    fr = '{8'd4, 8'd1, 8'd3, 8'd2, 8'd0};
    send_frame(fr, 0, 0, 0);
    idle();
    drain();

    // 6: back-to-back frames
    fr = '{8'd5, 8'd2, 8'd4, 8'd3, 8'd1};
    send_frame(fr, 0, 0, 0);
    fr = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    send_frame(fr, 0, 1, 0);
    idle();
    drain();

    // Randomized frames, random gaps and backpressure, some back-to-back
    for (int f = 0; f < 20; f++) begin
      or_mode = (f % 3 == 0) ? 0 : 2;
      for (int j = 0; j < N; j++)
        fr[j] = (f % 2 == 0) ? word_t'($urandom_range(0, 3)) : word_t'($urandom);
      send_frame(fr, 2, 0, 0);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
